arbitro_rr: RTL
===============

// Module: arbitro_rr
// PURPOSE
//  Round-robin scheduler between the 4 input FIFOs and the 4 output FIFOs of the switch datapath.
//  Pops one word at a time from a non-empty input FIFO, chosen round-robin rather than by fixed priority.
//  Routes the word by its destination field data[9:8] to the matching output FIFO.
//  If that output FIFO is almost full, the word is held until it has room.
// PARAMETERS
//  DATA_W   10  word width; destination field is [DATA_W-1:DATA_W-2]
//  CNT_W    8   width of per-output push counters (used only with ARB_RR_CNT_EN)
// PORTS
//  clk                      in   1       single clock, all logic on posedge
//  rst                      in   1       synchronous reset, active-low (rst==0 at posedge resets)
//  empty_0..empty_3         in   1 each  input FIFO n empty
//  data_poped_0..3          in   DATA_W  input FIFO n read data, valid the cycle after pop_n
//  alm_full_0..alm_full_3   in   1 each  output FIFO n almost full
//  pop_0..pop_3             out  1 each  registered pop strobe to input FIFO n
//  push_0..push_3           out  1 each  registered push strobe to output FIFO n
//  data_pushed_0..3         out  DATA_W  write data to output FIFO n
//  cnt_push_0..3            out  CNT_W   pushes per output (only with ARB_RR_CNT_EN)
// BEHAVIOUR
//  Reset: pop_*=0, push_*=0, data_pushed_*=0, cnt_push_*=0, rr_ptr=0, sel=0, hold=0, state=IDLE.
//  FSM (2-bit): IDLE -> POP -> CAPT -> IDLE or HOLD; HOLD -> IDLE.
//  IDLE: grant g = first n with empty_n==0, searching rr_ptr, rr_ptr+1, ... mod 4.
//   If a grant exists: pop_g<=1, sel<=g, rr_ptr<=(g+1) mod 4, state<=POP.
//   If no grant: stay in IDLE with all strobes 0.
//  POP: pop_sel is high for exactly this one cycle. Then pop_*<=0, state<=CAPT.
//  CAPT: d = data_poped_sel[DATA_W-1:DATA_W-2].
//   If alm_full_d==0: push_d<=1, data_pushed_d<=data_poped_sel, state<=IDLE.
//   Else: hold<=data_poped_sel, state<=HOLD.
//  HOLD: when alm_full_d==0: push_d<=1, data_pushed_d<=hold, state<=IDLE. Otherwise wait indefinitely.
//  push_* is a one-cycle pulse; at most one push_* and at most one pop_* are high per cycle.
//  data_pushed_n holds its last value while push_n==0.
//  Latency: pop high 1 cycle after IDLE sees a request; push high 2 cycles after pop, at earliest.
//   Peak throughput is 1 word per 3 cycles.
//  Input FIFO empty sampled when pop_sel is high: the word is discarded in CAPT.
//   No push occurs, state<=IDLE, rr_ptr is still advanced.
//  alm_full_d rising in the same cycle as CAPT: the word goes to HOLD and is never dropped.
//  Reset in any state, including HOLD: the held word is discarded and outputs return to reset values.
//  rr_ptr wraps 3 -> 0. With all 4 inputs non-empty, the grant order is 0,1,2,3,0,...
// CONFIGURATION
//  ARB_RR_CNT_EN defined:
//   cnt_push_0..3 ports exist; cnt_push_n increments on each push_n; saturates at 2^CNT_W-1.
//  ARB_RR_CNT_EN undefined:
//   counter ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared include arb_defs.vh holds:
//   state encodings ST_IDLE=0, ST_POP=1, ST_CAPT=2, ST_HOLD=3
//   NUM_PORTS=4, DEST_W=2
//  Sub-module rr_picker: combinational; inputs req[3:0] and ptr[1:0].
//   Outputs gnt_valid and gnt_idx[1:0]. Reusable by other schedulers.
// TESTING
//  Only FIFO 2 non-empty, word 10'h1A5 (dest 1), no alm_full:
//   pop_2 high 1 cycle, then push_1=1 with data_pushed_1=10'h1A5 two cycles later.
//  All FIFOs non-empty, rr_ptr=0, no alm_full:
//   pop order 0,1,2,3,0; each input gets exactly one pop per 4 grants.
//  Word 10'h3FF (dest 3) with alm_full_3=1 in CAPT:
//   HOLD, no push; after 5 cycles release alm_full_3 -> push_3=1, data 10'h3FF, next cycle IDLE.
//  rst=0 asserted during HOLD:
//   next posedge all outputs 0, state IDLE, no push of the held word after rst returns to 1.
//  ARB_RR_CNT_EN defined, 300 words routed to dest 0 with CNT_W=8: cnt_push_0 saturates at 255.
//  empty_1 forced to 1 during POP on FIFO 1: no push, rr_ptr=2, back to IDLE.

Source files
------------

// File: rtl/arbitro_rr_pkg.sv
// Shared types and sizes for the arbitro_rr round-robin scheduler and its picker.
package arbitro_rr_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;
    localparam int PTR_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping modulo NUM_PORTS.
module rr_picker
    import arbitro_rr_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 gnt_valid,
    output logic [PTR_W-1:0]     gnt_idx
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = ptr;
        // Walk from the farthest offset down so the nearest requester after ptr wins.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ptr + PTR_W'(i);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin scheduler: pops one word from a non-empty input FIFO and pushes it to the output FIFO
// selected by data[DATA_W-1:DATA_W-2]. Define ARB_RR_CNT_EN for saturating per-output push counters.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int DATA_W = 10
`ifdef ARB_RR_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              empty_3,
    input  logic [DATA_W-1:0] data_poped_0,
    input  logic [DATA_W-1:0] data_poped_1,
    input  logic [DATA_W-1:0] data_poped_2,
    input  logic [DATA_W-1:0] data_poped_3,
    input  logic              alm_full_0,
    input  logic              alm_full_1,
    input  logic              alm_full_2,
    input  logic              alm_full_3,
`ifdef ARB_RR_CNT_EN
    output logic [CNT_W-1:0]  cnt_push_0,
    output logic [CNT_W-1:0]  cnt_push_1,
    output logic [CNT_W-1:0]  cnt_push_2,
    output logic [CNT_W-1:0]  cnt_push_3,
`endif
    output logic              pop_0,
    output logic              pop_1,
    output logic              pop_2,
    output logic              pop_3,
    output logic              push_0,
    output logic              push_1,
    output logic              push_2,
    output logic              push_3,
    output logic [DATA_W-1:0] data_pushed_0,
    output logic [DATA_W-1:0] data_pushed_1,
    output logic [DATA_W-1:0] data_pushed_2,
    output logic [DATA_W-1:0] data_pushed_3
);

    logic [NUM_PORTS-1:0]             empty_v;
    logic [NUM_PORTS-1:0]             alm_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_poped_v;

    assign empty_v      = {empty_3, empty_2, empty_1, empty_0};
    assign alm_v        = {alm_full_3, alm_full_2, alm_full_1, alm_full_0};
    assign data_poped_v = {data_poped_3, data_poped_2, data_poped_1, data_poped_0};

    arb_state_e                       state_q, state_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                 sel_q, sel_d;
    logic                             drop_q, drop_d;
    logic [DATA_W-1:0]                hold_q, hold_d;
    logic [NUM_PORTS-1:0]             pop_q, pop_d;
    logic [NUM_PORTS-1:0]             push_q, push_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] dpush_q, dpush_d;

    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] word;
    logic [DEST_W-1:0] dest;

    rr_picker u_picker (
        .req       (~empty_v),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // CAPT routes the word straight off the FIFO read port; HOLD routes the parked copy.
    assign word = (state_q == ST_HOLD) ? hold_q : data_poped_v[sel_q];
    assign dest = word[DATA_W-1 -: DEST_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        drop_d   = drop_q;
        hold_d   = hold_q;
        pop_d    = '0;
        push_d   = '0;
        dpush_d  = dpush_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    pop_d[gnt_idx] = 1'b1;
                    sel_d          = gnt_idx;
                    rr_ptr_d       = gnt_idx + PTR_W'(1);
                    state_d        = ST_POP;
                end
            end
            ST_POP: begin
                drop_d  = empty_v[sel_q];
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                if (drop_q) begin
                    state_d = ST_IDLE;
                end else if (!alm_v[dest]) begin
                    push_d[dest]  = 1'b1;
                    dpush_d[dest] = word;
                    state_d       = ST_IDLE;
                end else begin
                    hold_d  = word;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!alm_v[dest]) begin
                    push_d[dest]  = 1'b1;
                    dpush_d[dest] = word;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            drop_q   <= 1'b0;
            hold_q   <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            dpush_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            dpush_q  <= dpush_d;
        end
    end

    assign pop_0         = pop_q[0];
    assign pop_1         = pop_q[1];
    assign pop_2         = pop_q[2];
    assign pop_3         = pop_q[3];
    assign push_0        = push_q[0];
    assign push_1        = push_q[1];
    assign push_2        = push_q[2];
    assign push_3        = push_q[3];
    assign data_pushed_0 = dpush_q[0];
    assign data_pushed_1 = dpush_q[1];
    assign data_pushed_2 = dpush_q[2];
    assign data_pushed_3 = dpush_q[3];

`ifdef ARB_RR_CNT_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counters move in the same cycle as the push strobe they count.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_push_0 = cnt_q[0];
    assign cnt_push_1 = cnt_q[1];
    assign cnt_push_2 = cnt_q[2];
    assign cnt_push_3 = cnt_q[3];
`endif

endmodule
